// File: rtl/bsg_clz_pkg.sv
// Shared types and helpers for the leading-zero count / denormalize datapath.
package bsg_clz_pkg;
  localparam int clz_width_gp    = 16;
  localparam int clz_lg_width_gp = $clog2(clz_width_gp);
  localparam int clz_lo_w_gp     = clz_lg_width_gp / 2;

  typedef struct packed {
    logic [clz_width_gp-1:0] data;
    logic [clz_lo_w_gp-1:0]  shift_lo;
    logic                    zero;
  } clz_stage_s;

  // A normalized operand must have its MSB set; a zero operand must be all zeros.
  function automatic logic clz_malformed(input logic [clz_width_gp-1:0] data,
                                         input logic                    zero);
    return zero ? (|data) : ~data[clz_width_gp-1];
  endfunction
endpackage

// File: rtl/bsg_clz_denormalize_if.sv
// Producer (valid/ready) and consumer (valid/yumi) sides of the denormalizer.
interface bsg_clz_denormalize_if
  import bsg_clz_pkg::*;
#(parameter int width_p = clz_width_gp);
  localparam int lg_width_lp = $clog2(width_p);

  logic                   v_i;
  logic [width_p-1:0]     data_i;
  logic [lg_width_lp-1:0] shift_i;
  logic                   zero_i;
  logic                   ready_o;
  logic                   v_o;
  logic [width_p-1:0]     data_o;
  logic                   yumi_i;
  logic                   illegal_o;

  modport slave  (input  v_i, data_i, shift_i, zero_i, yumi_i,
                  output ready_o, v_o, data_o, illegal_o);
  modport master (output v_i, data_i, shift_i, zero_i, yumi_i,
                  input  ready_o, v_o, data_o, illegal_o);
endinterface

// File: rtl/bsg_clz_shift_stage.sv
// Registered right-shift stage: shifts by sh_i * 2^gran_p, optionally forcing zero.
module bsg_clz_shift_stage
  import bsg_clz_pkg::*;
#(
  parameter int sh_w_p       = 2,
  parameter int gran_p       = 0,
  parameter bit force_zero_p = 1'b0
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              en_i,
  input  logic              v_i,
  input  logic [sh_w_p-1:0] sh_i,
  input  clz_stage_s        pay_i,
  output logic              v_o,
  output clz_stage_s        pay_o
);
  localparam int amt_w_lp = sh_w_p + gran_p;

  logic [amt_w_lp-1:0] amt;
  clz_stage_s          pay_d, pay_q;
  logic                v_q;

  always_comb begin
    amt        = amt_w_lp'(sh_i) << gran_p;
    pay_d      = pay_i;
    pay_d.data = pay_i.data >> amt;
    if (force_zero_p && pay_i.zero) pay_d.data = '0;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_q   <= 1'b0;
      pay_q <= '0;
    end else if (en_i) begin
      v_q   <= v_i;
      pay_q <= pay_d;
    end
  end

  assign v_o   = v_q;
  assign pay_o = pay_q;
endmodule

// File: rtl/bsg_clz_denormalize.sv
// Two-stage pipelined inverse of the leading-zero normalizer (restores magnitude by right shift).
module bsg_clz_denormalize
  import bsg_clz_pkg::*;
#(parameter int width_p = clz_width_gp) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  bsg_clz_denormalize_if.slave   io
);
  localparam int lg_width_lp = $clog2(width_p);
  localparam int lo_w_lp     = lg_width_lp / 2;
  localparam int hi_w_lp     = lg_width_lp - lo_w_lp;

  logic       s1_v, s2_v, adv, s1_en, accept;
  logic       illegal_q, illegal_d;
  clz_stage_s s1_in, s1_pay, s2_pay;
  logic       unused_s2;

  // Stage 2 drains on empty or yumi; stage 1 may refill whenever stage 2 moves.
  assign adv        = ~s2_v | io.yumi_i;
  assign s1_en      = ~s1_v | adv;
  assign io.ready_o = s1_en;
  assign accept     = io.v_i & s1_en;

  assign s1_in = '{data:     io.data_i,
                   shift_lo: io.shift_i[lo_w_lp-1:0],
                   zero:     io.zero_i};

  bsg_clz_shift_stage #(.sh_w_p(hi_w_lp), .gran_p(lo_w_lp), .force_zero_p(1'b0)) u_s1 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (s1_en),
    .v_i       (io.v_i),
    .sh_i      (io.shift_i[lg_width_lp-1:lo_w_lp]),
    .pay_i     (s1_in),
    .v_o       (s1_v),
    .pay_o     (s1_pay)
  );

  bsg_clz_shift_stage #(.sh_w_p(lo_w_lp), .gran_p(0), .force_zero_p(1'b1)) u_s2 (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (adv),
    .v_i       (s1_v),
    .sh_i      (s1_pay.shift_lo),
    .pay_i     (s1_pay),
    .v_o       (s2_v),
    .pay_o     (s2_pay)
  );

  assign unused_s2 = ^{s2_pay.shift_lo, s2_pay.zero};

  assign illegal_d = illegal_q | (accept & clz_malformed(io.data_i, io.zero_i));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) illegal_q <= 1'b0;
    else            illegal_q <= illegal_d;
  end

  assign io.v_o       = s2_v;
  assign io.data_o    = s2_pay.data;
  assign io.illegal_o = illegal_q;
endmodule

// File: tb/tb_bsg_clz_denormalize.sv
// Directed and round-trip checks for bsg_clz_denormalize.
module tb_bsg_clz_denormalize;
  logic clk_i = 1'b0;
  logic reset_n_i;
  int   errors = 0;
  int   checks = 0;

  bsg_clz_denormalize_if #(.width_p(16)) io ();

  bsg_clz_denormalize #(.width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .io        (io)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] s, input logic z);
    io.v_i = v; io.data_i = d; io.shift_i = s; io.zero_i = z;
  endtask

  function automatic int clz16(input logic [15:0] x);
    for (int i = 15; i >= 0; i--) if (x[i]) return 15 - i;
    return 16;
  endfunction

  task automatic do_reset();
    reset_n_i = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    io.yumi_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (io.v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o got=%b exp=0", io.v_o); end
    checks++; if (io.data_o !== 16'h0) begin errors++; $display("FAIL reset_data_o got=%h exp=0000", io.data_o); end
    checks++; if (io.illegal_o !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", io.illegal_o); end
    checks++; if (io.ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", io.ready_o); end
  endtask

  task automatic test_single();
    io.yumi_i = 1'b1;
    drive(1'b1, 16'h8000, 4'd15, 1'b0);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    checks++; if (io.v_o !== 1'b0) begin errors++; $display("FAIL single_early_v got=%b exp=0", io.v_o); end
    step();
    checks++; if (io.v_o !== 1'b1) begin errors++; $display("FAIL single_v got=%b exp=1", io.v_o); end
    checks++; if (io.data_o !== 16'h0001) begin errors++; $display("FAIL single_data got=%h exp=0001", io.data_o); end
    checks++; if (io.illegal_o !== 1'b0) begin errors++; $display("FAIL single_illegal got=%b exp=0", io.illegal_o); end
    step();
    checks++; if (io.v_o !== 1'b0) begin errors++; $display("FAIL single_drained got=%b exp=0", io.v_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] din [3] = '{16'hF000, 16'h8001, 16'hC000};
    logic [3:0]  sin [3] = '{4'd3, 4'd0, 4'd8};
    logic [15:0] dex [3] = '{16'h1E00, 16'h8001, 16'h00C0};
    io.yumi_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(1'b1, din[i], sin[i], 1'b0);
      else       drive(1'b0, 16'h0, 4'h0, 1'b0);
      #1;
      if (i < 3) begin
        checks++; if (io.ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%b exp=1", i, io.ready_o); end
      end
      step();
      if (i >= 1 && i <= 3) begin
        checks++; if (io.v_o !== 1'b1 || io.data_o !== dex[i-1]) begin
          errors++; $display("FAIL b2b_out[%0d] got v=%b d=%h exp v=1 d=%h", i-1, io.v_o, io.data_o, dex[i-1]);
        end
      end
    end
    checks++; if (io.v_o !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", io.v_o); end
  endtask

  task automatic test_stall();
    logic [15:0] din [3] = '{16'hF000, 16'h8000, 16'hA000};
    logic [3:0]  sin [3] = '{4'd4, 4'd1, 4'd2};
    logic [15:0] dex [3] = '{16'h0F00, 16'h4000, 16'h2800};
    io.yumi_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, din[i], sin[i], 1'b0);
      #1;
      checks++; if (io.ready_o !== 1'b1) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=1", i, io.ready_o); end
      step();
    end
    drive(1'b1, din[2], sin[2], 1'b0);
    #1;
    checks++; if (io.ready_o !== 1'b0) begin errors++; $display("FAIL stall_full_ready got=%b exp=0", io.ready_o); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++; if (io.v_o !== 1'b1 || io.data_o !== dex[0] || io.ready_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b d=%h r=%b exp v=1 d=%h r=0", k, io.v_o, io.data_o, io.ready_o, dex[0]);
      end
    end
    io.yumi_i = 1'b1;
    #1;
    checks++; if (io.ready_o !== 1'b1) begin errors++; $display("FAIL stall_yumi_ready got=%b exp=1", io.ready_o); end
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    checks++; if (io.v_o !== 1'b1 || io.data_o !== dex[1]) begin errors++; $display("FAIL stall_out1 got v=%b d=%h exp d=%h", io.v_o, io.data_o, dex[1]); end
    step();
    checks++; if (io.v_o !== 1'b1 || io.data_o !== dex[2]) begin errors++; $display("FAIL stall_out2 got v=%b d=%h exp d=%h", io.v_o, io.data_o, dex[2]); end
    step();
    checks++; if (io.v_o !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b exp=0", io.v_o); end
  endtask

  task automatic test_zero_illegal();
    io.yumi_i = 1'b1;
    drive(1'b1, 16'h0000, 4'd7, 1'b1);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    step();
    checks++; if (io.v_o !== 1'b1 || io.data_o !== 16'h0) begin errors++; $display("FAIL zero_data got v=%b d=%h exp v=1 d=0000", io.v_o, io.data_o); end
    checks++; if (io.illegal_o !== 1'b0) begin errors++; $display("FAIL zero_illegal got=%b exp=0", io.illegal_o); end
    drive(1'b1, 16'h4000, 4'd3, 1'b0);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    checks++; if (io.illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_set got=%b exp=1", io.illegal_o); end
    step();
    checks++; if (io.v_o !== 1'b1 || io.data_o !== 16'h0800) begin errors++; $display("FAIL illegal_data got v=%b d=%h exp v=1 d=0800", io.v_o, io.data_o); end
    step(); step(); step();
    checks++; if (io.illegal_o !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%b exp=1", io.illegal_o); end
  endtask

  task automatic test_reset_midstall();
    io.yumi_i = 1'b0;
    drive(1'b1, 16'h8000, 4'd2, 1'b0);
    step(); step();
    #1;
    checks++; if (io.ready_o !== 1'b0 || io.v_o !== 1'b1) begin errors++; $display("FAIL mid_full got r=%b v=%b exp r=0 v=1", io.ready_o, io.v_o); end
    reset_n_i = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    #1;
    checks++; if (io.v_o !== 1'b0 || io.ready_o !== 1'b1 || io.illegal_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b r=%b ill=%b exp v=0 r=1 ill=0", io.v_o, io.ready_o, io.illegal_o);
    end
    step();
    reset_n_i = 1'b1;
    io.yumi_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (io.v_o !== 1'b0) begin errors++; $display("FAIL mid_spurious[%0d] got=%b exp=0", k, io.v_o); end
    end
  endtask

  task automatic test_round_trip();
    logic [15:0] q[$];
    logic [15:0] x, nxt;
    int          sent = 0, rcvd = 0, cyc = 0;
    nxt = 16'(($urandom_range(65535, 1)));
    io.yumi_i = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    while (rcvd < 10000 && cyc < 60000) begin
      io.yumi_i = io.v_o & ($urandom_range(3, 0) != 0);
      if (sent < 10000 && $urandom_range(7, 0) != 0)
        drive(1'b1, nxt << clz16(nxt), 4'(clz16(nxt)), 1'b0);
      else
        drive(1'b0, 16'h0, 4'h0, 1'b0);
      #1;
      if (io.v_o && io.yumi_i) begin
        x = (q.size() != 0) ? q.pop_front() : 16'hxxxx;
        checks++; if (io.data_o !== x) begin errors++; $display("FAIL rt_data[%0d] got=%h exp=%h", rcvd, io.data_o, x); end
        rcvd++;
      end
      if (io.v_i && io.ready_o) begin
        q.push_back(nxt);
        sent++;
        nxt = 16'(($urandom_range(65535, 1)));
      end
      step();
      cyc++;
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    io.yumi_i = 1'b0;
    checks++; if (rcvd != 10000) begin errors++; $display("FAIL rt_timeout got=%0d exp=10000", rcvd); end
    checks++; if (io.illegal_o !== 1'b0) begin errors++; $display("FAIL rt_illegal got=%b exp=0", io.illegal_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_zero_illegal();
    test_reset_midstall();
    test_round_trip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
